// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: sequencing controller between the keypad priority encoder
// and the cook timer. It debounces encoder digits and shifts them into a
// 4-digit BCD MM:SS entry register. It also runs the IDLE/ENTRY/COOK/PAUSE
// machine from start/stop/door, and locks the keypad while cooking or paused.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_code     : encoder digit
//   key_valid    : encoder valid
//   start        : start/resume request (level)
//   stop         : stop/clear request (level)
//   door_open    : 1 = door open
//   timer_done   : cook timer reached 00:00
//   kp_enable    : 1 locks the keypad (COOK/PAUSE)
//   time_bcd     : {M1,M0,S1,S0} entry value
//   load         : one-cycle pulse to load time_bcd into the timer
//   run          : 1 = timer counts down
//   state        : IDLE=00, ENTRY=01, COOK=10, PAUSE=11
module keypad_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  input  logic        start,
  input  logic        stop,
  input  logic        door_open,
  input  logic        timer_done,
  output logic        kp_enable,
  output logic [15:0] time_bcd,
  output logic        load,
  output logic        run,
  output logic [1:0]  state
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned TIME_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ENTRY = 2'b01,
    S_COOK  = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic                load_q, load_d;
  logic                run_q, run_d;
  logic                kp_q, kp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   held_q, held_d;
  logic                armed_q, armed_d;
  logic                keys_active;
  logic                accept;
  logic [TIME_W-1:0]   shifted;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      time_q  <= '0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      kp_q    <= 1'b0;
      cnt_q   <= '0;
      held_q  <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      load_q  <= load_d;
      run_q   <= run_d;
      kp_q    <= kp_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      armed_q <= armed_d;
    end
  end

  // Debounce, key acceptance and next-state/output logic
  always_comb begin
    cnt_d       = cnt_q;
    held_d      = held_q;
    armed_d     = armed_q;
    accept      = 1'b0;
    state_d     = state_q;
    time_d      = time_q;
    load_d      = 1'b0;
    keys_active = (state_q == S_IDLE) || (state_q == S_ENTRY);
    shifted     = {time_q[11:0], key_code};

    if (!keys_active) begin
      // Locked keypad: a key must be released after unlock before it counts
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (!key_valid) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (key_code != held_q) begin
      held_d = key_code;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (keys_active && key_valid && armed_q &&
        (cnt_d == CNT_W'(DEBOUNCE_CYCLES)) && (key_code <= CODE_W'(9))) begin
      accept  = 1'b1;
      armed_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ENTRY;
          time_d  = shifted;
        end
      end
      S_ENTRY: begin
        if (stop) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (accept) begin
          time_d = shifted;
        end else if (start && !door_open && (time_q != '0)) begin
          state_d = S_COOK;
          load_d  = 1'b1;
        end
      end
      S_COOK: begin
        if (timer_done) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (stop || door_open) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (start && !door_open) begin
          state_d = S_COOK;
        end
      end
    endcase

    run_d = (state_d == S_COOK);
    kp_d  = (state_d == S_COOK) || (state_d == S_PAUSE);
  end

  assign state     = state_q;
  assign time_bcd  = time_q;
  assign load      = load_q;
  assign run       = run_q;
  assign kp_enable = kp_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: directed vector table, hand-written
// asynchronous reset sequence, and a randomized run against a reference model.
module tb_keypad_entry_ctrl;

  localparam int DEB = 4;

  logic        clk, rst_n;
  logic [3:0]  key_code;
  logic        key_valid, start, stop, door_open, timer_done;
  logic        kp_enable, load, run;
  logic [15:0] time_bcd;
  logic [1:0]  state;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .start(start), .stop(stop), .door_open(door_open), .timer_done(timer_done),
    .kp_enable(kp_enable), .time_bcd(time_bcd), .load(load), .run(run),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        st, sp, dr, td;
    int          n;
    logic [1:0]  es;
    logic [15:0] et;
    logic        el, er, ek;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic kv, input logic [3:0] kc, input logic st,
                     input logic sp, input logic dr, input logic td, input int n,
                     input logic [1:0] es, input logic [15:0] et,
                     input logic el, input logic er, input logic ek);
    vec_t v;
    v.kv = kv; v.kc = kc; v.st = st; v.sp = sp; v.dr = dr; v.td = td; v.n = n;
    v.es = es; v.et = et; v.el = el; v.er = er; v.ek = ek;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] es, input logic [15:0] et,
                          input logic el, input logic er, input logic ek);
    chk({tag, ".state"}, 16'(state), 16'(es));
    chk({tag, ".time"}, time_bcd, et);
    chk({tag, ".load"}, 16'(load), 16'(el));
    chk({tag, ".run"}, 16'(run), 16'(er));
    chk({tag, ".kp"}, 16'(kp_enable), 16'(ek));
  endtask

  task automatic drive(input logic kv, input logic [3:0] kc, input logic st,
                       input logic sp, input logic dr, input logic td);
    key_valid = kv; key_code = kc; start = st; stop = sp; door_open = dr; timer_done = td;
  endtask

  // Reference model: trailing run of identical valid samples, an "armed" flag
  // re-set by any release seen while unlocked, and the mode rules as arithmetic.
  int m_state, m_time, m_run_len, m_prev_code;
  bit m_armed, m_load;

  task automatic model_reset();
    m_state = 0; m_time = 0; m_run_len = 0; m_prev_code = 0; m_armed = 1; m_load = 0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit st, input bit sp,
                            input bit dr, input bit td);
    bit acc;
    int nxt_time;
    acc = 0;
    if (m_state <= 1) begin
      if (!kv) begin
        m_run_len = 0;
        m_armed = 1;
      end else begin
        m_run_len = (m_run_len > 0 && kc == m_prev_code) ? m_run_len + 1 : 1;
        m_prev_code = kc;
        if (m_run_len == DEB && m_armed && kc <= 9) begin
          acc = 1;
          m_armed = 0;
        end
      end
    end else begin
      m_run_len = 0;
      m_armed = 0;
    end
    nxt_time = (m_time % 4096) * 16 + kc;
    m_load = 0;
    case (m_state)
      0: if (acc) begin m_state = 1; m_time = nxt_time; end
      1: begin
        if (sp) begin m_state = 0; m_time = 0; end
        else if (acc) m_time = nxt_time;
        else if (st && !dr && m_time != 0) begin m_state = 2; m_load = 1; end
      end
      2: begin
        if (td) begin m_state = 0; m_time = 0; end
        else if (sp || dr) m_state = 3;
      end
      default: begin
        if (sp) begin m_state = 0; m_time = 0; end
        else if (st && !dr) m_state = 2;
      end
    endcase
  endtask

  task automatic press_rows(input logic [3:0] kc, input logic [1:0] es, input logic [15:0] et);
    add(1, kc, 0, 0, 0, 0, DEB, es, et, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, es, et, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pressing;
    int seg_left, code;
    bit r_st, r_sp, r_td, r_door;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk_outs("reset", 2'd0, 16'h0000, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Entry, glitch rejection, held key, wrap
    add(1, 1, 0, 0, 0, 0, 3, 0, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 1, 16'h0001, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 16'h0001, 0, 0, 0);
    press_rows(3, 1, 16'h0013);
    press_rows(0, 1, 16'h0130);
    add(1, 5, 0, 0, 0, 0, 3, 1, 16'h0130, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 16'h0130, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0, 50, 1, 16'h1307, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 16'h1307, 0, 0, 0);
    press_rows(1, 1, 16'h3071);
    press_rows(2, 1, 16'h0712);
    press_rows(3, 1, 16'h7123);
    press_rows(4, 1, 16'h1234);
    press_rows(5, 1, 16'h2345);
    // Clear, enter 0030, start gated by door, cook/pause/resume/done
    add(0, 0, 0, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    press_rows(3, 1, 16'h0003);
    press_rows(0, 1, 16'h0030);
    add(0, 0, 1, 0, 1, 0, 1, 1, 16'h0030, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 2, 16'h0030, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 2, 16'h0030, 0, 1, 1);
    add(1, 9, 0, 0, 0, 0, 6, 2, 16'h0030, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 2, 16'h0030, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 1, 3, 16'h0030, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1, 3, 16'h0030, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 2, 16'h0030, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0);
    // Release seen in IDLE re-arms; done beats stop
    add(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    press_rows(1, 1, 16'h0001);
    add(0, 0, 1, 0, 0, 0, 1, 2, 16'h0001, 1, 1, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0, 16'h0000, 0, 0, 0);
    // No release seen since unlock: press ignored
    add(1, 2, 0, 0, 0, 0, DEB, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    press_rows(2, 1, 16'h0002);
    add(0, 0, 1, 0, 0, 0, 1, 2, 16'h0002, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 3, 16'h0002, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    // Key held across done is not accepted
    add(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    press_rows(4, 1, 16'h0004);
    add(0, 0, 1, 0, 0, 0, 1, 2, 16'h0004, 1, 1, 1);
    add(1, 4, 0, 0, 0, 0, 3, 2, 16'h0004, 0, 1, 1);
    add(1, 4, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 0, 0);
    add(1, 4, 0, 0, 0, 0, 10, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    // Entry of 0000 cannot start
    press_rows(0, 1, 16'h0000);
    add(0, 0, 1, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    // Non-digit code never accepted
    add(1, 12, 0, 0, 0, 0, 6, 1, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    press_rows(5, 1, 16'h0005);
    add(0, 0, 1, 0, 0, 0, 1, 2, 16'h0005, 1, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].kv, tbl[i].kc, tbl[i].st, tbl[i].sp, tbl[i].dr, tbl[i].td);
      repeat (tbl[i].n) @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].es, tbl[i].et, tbl[i].el, tbl[i].er, tbl[i].ek);
    end

    // Asynchronous reset during COOK takes effect before the next edge
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_outs("precook", 2'd2, 16'h0005, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1 chk_outs("async_rst", 2'd0, 16'h0000, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("post_rst", 2'd0, 16'h0000, 0, 0, 0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    pressing = 0; seg_left = 0; code = 0; r_door = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (seg_left == 0) begin
        pressing = !pressing;
        seg_left = pressing ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 3));
        code = int'($urandom_range(0, 11));
      end
      seg_left--;
      if (pressing && ($urandom % 12) == 0) code = int'($urandom_range(0, 11));
      r_st = (($urandom % 6) == 0);
      r_sp = (($urandom % 40) == 0);
      r_td = (($urandom % 25) == 0);
      if (($urandom % 16) == 0) r_door = !r_door;
      drive(pressing, 4'(code), r_st, r_sp, r_door, r_td);
      @(posedge clk);
      model_step(pressing, code, r_st, r_sp, r_door, r_td);
      #1;
      chk_outs($sformatf("rnd%0d", cyc), 2'(m_state), 16'(m_time), m_load,
               m_state == 2, m_state >= 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
